// File: rtl/ro_puf_pkg.sv
// Shared types for the ring-oscillator PUF challenge/response controller.
package ro_puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_COUNT   = 3'd2,
      ST_COMPARE = 3'd3,
      ST_DONE    = 3'd4
   } puf_state_t;

   // Measurement rounds per challenge when majority voting is built in
   localparam int VOTE_ROUNDS = 3;

   typedef struct packed {
      logic rbit;
      logic tie;
      logic sat;
      logic err;
   } puf_resp_t;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// One oscillator channel: 2-flop synchronizer, rising-edge detect and a
// saturating edge counter with synchronous clear and count enable.
module ro_edge_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ro_in,
   input  logic             clr,
   input  logic             cnt_en,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic sync1;
   logic sync2;
   logic prev;
   logic rise;

   // bring the raw oscillator into clk and keep one cycle of history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= ro_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rise = sync2 & ~prev;
   assign sat  = (count == CNT_MAX);

   // count rising edges, sticking at all-ones instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (cnt_en && rise && !sat) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF challenge/response sequencer. Enables the challenged
// pair, counts both over a fixed window and reports which ran faster.
// Optional build macro: RO_PUF_VOTE_EN (three rounds, majority response).
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | ready for a challenge, oscillators off
//  ST_SETTLE  | pair enabled, counters held clear, SETTLE cycles
//  ST_COUNT   | pair enabled, counting edges for WINDOW cycles
//  ST_COMPARE | oscillators off, response computed and registered
//  ST_DONE    | response valid until the host takes it
module ro_puf_ctrl
   import ro_puf_pkg::*;
#(
   parameter int NUM_RO = 16,
   parameter int SEL_W  = 4,
   parameter int CNT_W  = 16,
   parameter int WINDOW = 1024,
   parameter int SETTLE = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              chal_valid,
   output logic              chal_ready,
   input  logic [SEL_W-1:0]  chal_a,
   input  logic [SEL_W-1:0]  chal_b,
   output logic [NUM_RO-1:0] ro_en,
   input  logic [NUM_RO-1:0] ro_out,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_bit,
   output logic              resp_tie,
   output logic              resp_sat,
   output logic              resp_err,
   output logic [CNT_W-1:0]  count_a,
   output logic [CNT_W-1:0]  count_b
);

   localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
   localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
   localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW - 1);

   puf_state_t        state;
   puf_state_t        state_nxt;
   logic [TMR_W-1:0]  tmr;
   logic [SEL_W-1:0]  sel_a;
   logic [SEL_W-1:0]  sel_b;
   logic [SEL_W-1:0]  a_nxt;
   logic [SEL_W-1:0]  b_nxt;
   logic [NUM_RO-1:0] en_nxt;
   logic              accept;
   logic              a_ok;
   logic              b_ok;
   logic              chal_legal;
   logic              mux_a;
   logic              mux_b;
   logic [CNT_W-1:0]  cnt_a_raw;
   logic [CNT_W-1:0]  cnt_b_raw;
   logic              sat_a;
   logic              sat_b;
   logic              gt;
   logic              eq;
   logic              last_round;
   puf_resp_t         resp_q;

   assign chal_ready = (state == ST_IDLE);
   assign accept     = chal_valid & chal_ready;
   assign chal_legal = a_ok & b_ok & (chal_a != chal_b);
   assign a_nxt      = (state == ST_IDLE) ? chal_a : sel_a;
   assign b_nxt      = (state == ST_IDLE) ? chal_b : sel_b;
   assign gt         = (cnt_a_raw > cnt_b_raw);
   assign eq         = (cnt_a_raw == cnt_b_raw);

`ifdef RO_PUF_VOTE_EN
   logic [1:0] rnd;
   logic [2:0] votes;
   logic [2:0] vote_now;

   assign last_round = (rnd == 2'(VOTE_ROUNDS - 1));

   // this round's comparison merged into the votes collected so far
   always_comb begin
      vote_now = votes;
      case (rnd)
         2'd0:    vote_now[0] = gt;
         2'd1:    vote_now[1] = gt;
         default: vote_now[2] = gt;
      endcase
   end
`else
   assign last_round = 1'b1;
`endif

   // index range check on the incoming challenge and the NUM_RO:1 muxes
   always_comb begin
      a_ok  = 1'b0;
      b_ok  = 1'b0;
      mux_a = 1'b0;
      mux_b = 1'b0;
      for (int i = 0; i < NUM_RO; i++) begin
         if (chal_a == SEL_W'(i)) a_ok = 1'b1;
         if (chal_b == SEL_W'(i)) b_ok = 1'b1;
         if (sel_a == SEL_W'(i)) mux_a = ro_out[i];
         if (sel_b == SEL_W'(i)) mux_b = ro_out[i];
      end
   end

   // next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (accept) state_nxt = chal_legal ? ST_SETTLE : ST_DONE;
         ST_SETTLE:  if (tmr == '0) state_nxt = ST_COUNT;
         ST_COUNT:   if (tmr == '0) state_nxt = ST_COMPARE;
         ST_COMPARE: state_nxt = last_round ? ST_DONE : ST_SETTLE;
         ST_DONE:    if (resp_ready) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // enables follow the next state so ro_en comes straight from a flop
   always_comb begin
      en_nxt = '0;
      if (state_nxt == ST_SETTLE || state_nxt == ST_COUNT) begin
         for (int i = 0; i < NUM_RO; i++) begin
            if (a_nxt == SEL_W'(i) || b_nxt == SEL_W'(i)) en_nxt[i] = 1'b1;
         end
      end
   end

   // state, enables, challenge capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         ro_en <= '0;
         sel_a <= '0;
         sel_b <= '0;
      end else begin
         state <= state_nxt;
         ro_en <= en_nxt;
         if (accept) begin
            sel_a <= chal_a;
            sel_b <= chal_b;
         end
      end
   end

   // phase down-counter, reloaded on entry to SETTLE and COUNT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr <= '0;
      end else if (state_nxt == ST_SETTLE && state != ST_SETTLE) begin
         tmr <= SETTLE_LD;
      end else if (state_nxt == ST_COUNT && state != ST_COUNT) begin
         tmr <= WINDOW_LD;
      end else if (tmr != '0) begin
         tmr <= tmr - 1'b1;
      end
   end

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .ro_in  (mux_a),
      .clr    (state == ST_SETTLE),
      .cnt_en (state == ST_COUNT),
      .count  (cnt_a_raw),
      .sat    (sat_a)
   );

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .ro_in  (mux_b),
      .clr    (state == ST_SETTLE),
      .cnt_en (state == ST_COUNT),
      .count  (cnt_b_raw),
      .sat    (sat_b)
   );

   // response register: cleared on acceptance, loaded in COMPARE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_q  <= '0;
         count_a <= '0;
         count_b <= '0;
`ifdef RO_PUF_VOTE_EN
         rnd     <= '0;
         votes   <= '0;
`endif
      end else if (accept) begin
         resp_q     <= '0;
         resp_q.err <= ~chal_legal;
         count_a    <= '0;
         count_b    <= '0;
`ifdef RO_PUF_VOTE_EN
         rnd        <= '0;
         votes      <= '0;
`endif
      end else if (state == ST_COMPARE) begin
         count_a <= cnt_a_raw;
         count_b <= cnt_b_raw;
`ifdef RO_PUF_VOTE_EN
         votes       <= vote_now;
         rnd         <= rnd + 1'b1;
         resp_q.rbit <= maj3(vote_now[0], vote_now[1], vote_now[2]);
         resp_q.tie  <= resp_q.tie | eq;
         resp_q.sat  <= resp_q.sat | sat_a | sat_b;
`else
         resp_q.rbit <= gt;
         resp_q.tie  <= eq;
         resp_q.sat  <= sat_a | sat_b;
`endif
      end
   end

   assign resp_valid = (state == ST_DONE);
   assign resp_bit   = resp_q.rbit;
   assign resp_tie   = resp_q.tie;
   assign resp_sat   = resp_q.sat;
   assign resp_err   = resp_q.err;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Bench for ro_puf_ctrl: behavioural oscillators, edge counts taken directly
// from the modelled waveforms, response and timing derived from those counts.
module tb_ro_puf_ctrl;

   localparam int NRO = 16;
   localparam int SW  = 5;
   localparam int S   = 8;
   localparam int W   = 1024;
`ifdef RO_PUF_VOTE_EN
   localparam int ROUNDS = 3;
`else
   localparam int ROUNDS = 1;
`endif
   localparam int SS = 4;
   localparam int SWIN = 128;

   logic clk;
   logic rst_n;

   logic            chal_valid, chal_ready;
   logic [SW-1:0]   chal_a, chal_b;
   logic [NRO-1:0]  ro_en, ro_out;
   logic            resp_valid, resp_ready, resp_bit, resp_tie, resp_sat, resp_err;
   logic [15:0]     count_a, count_b;

   logic            s_valid, s_ready;
   logic [SW-1:0]   s_a, s_b;
   logic [NRO-1:0]  s_en, s_out;
   logic            s_rvalid, s_rready, s_bit, s_tie, s_sat, s_err;
   logic [3:0]      s_cnt_a, s_cnt_b;
   logic            osc4;

   int n_chk = 0;
   int n_err = 0;

   int  per     [NRO];
   int  off     [NRO];
   int  ph      [NRO];
   int  ref_cnt [NRO];
   logic win_on;

   ro_puf_ctrl #(.NUM_RO(NRO), .SEL_W(SW), .CNT_W(16), .WINDOW(W), .SETTLE(S)) dut (
      .clk(clk), .rst_n(rst_n),
      .chal_valid(chal_valid), .chal_ready(chal_ready),
      .chal_a(chal_a), .chal_b(chal_b),
      .ro_en(ro_en), .ro_out(ro_out),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_bit(resp_bit), .resp_tie(resp_tie), .resp_sat(resp_sat), .resp_err(resp_err),
      .count_a(count_a), .count_b(count_b)
   );

   ro_puf_ctrl #(.NUM_RO(NRO), .SEL_W(SW), .CNT_W(4), .WINDOW(SWIN), .SETTLE(SS)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .chal_valid(s_valid), .chal_ready(s_ready),
      .chal_a(s_a), .chal_b(s_b),
      .ro_en(s_en), .ro_out(s_out),
      .resp_valid(s_rvalid), .resp_ready(s_rready),
      .resp_bit(s_bit), .resp_tie(s_tie), .resp_sat(s_sat), .resp_err(s_err),
      .count_a(s_cnt_a), .count_b(s_cnt_b)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // 4-clk free-running oscillator gated by the small instance's enables
   initial begin
      osc4 = 1'b0;
      #3;
      forever #40 osc4 = ~osc4;
   end
   assign s_out = s_en & {NRO{osc4}};

   // oscillator array: one model step every 2 time units, off the clk edges
   initial begin
      logic nv;
      ro_out = '0;
      win_on = 1'b0;
      for (int i = 0; i < NRO; i++) begin
         per[i] = 100; off[i] = 0; ph[i] = 0; ref_cnt[i] = 0;
      end
      #1;
      forever begin
         for (int i = 0; i < NRO; i++) begin
            if (!ro_en[i]) begin
               ph[i] = off[i];
               nv = 1'b0;
            end else begin
               ph[i] = ph[i] + 1;
               nv = ((ph[i] % per[i]) < (per[i] / 2));
            end
            if (nv && !ro_out[i] && win_on) ref_cnt[i] = ref_cnt[i] + 1;
            ro_out[i] = nv;
         end
         #2;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_chk, n_err);
      $fatal(1);
   end

   task automatic chk(input string tag, input longint obs, input longint exp, input int tol);
      longint d;
      n_chk++;
      d = (obs > exp) ? obs - exp : exp - obs;
      if (d > tol) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (tolerance %0d)", tag, obs, exp, tol);
      end
   endtask

   task automatic set_osc(input int i, input int p, input int o);
      per[i] = p;
      off[i] = o;
   endtask

   task automatic run_chal(input int a, input int b, input bit same);
      bit          legal;
      int          n, got, en_bad, base, exp_cyc, pos, rd, hold_bad, ra, rb;
      logic [NRO-1:0] pair, exp_mask;
      logic [35:0] snap;
      legal   = (a != b) && (a < NRO) && (b < NRO);
      pair    = '0;
      if (legal) begin
         pair[a] = 1'b1; pair[b] = 1'b1;
         ref_cnt[a] = 0; ref_cnt[b] = 0;
      end
      exp_cyc = legal ? ROUNDS * (S + W + 1) + 1 : 1;
      base    = (ROUNDS - 1) * (S + W + 1);

      @(negedge clk);
      chk("chal_ready_idle", chal_ready, 1, 0);
      chal_a = SW'(a);
      chal_b = SW'(b);
      chal_valid = 1'b1;
      resp_ready = 1'($urandom % 2);
      @(posedge clk); #1;
      chal_valid = 1'b0;

      n = 1; got = -1; en_bad = 0;
      while (got < 0 && n <= exp_cyc + 50) begin
         rd  = (n - 1) / (S + W + 1);
         pos = (n - 1) % (S + W + 1) + 1;
         exp_mask = (legal && rd < ROUNDS && pos <= S + W) ? pair : '0;
         if (ro_en !== exp_mask) en_bad++;
         if (legal && n == base + S + 1) win_on = 1'b1;
         if (n == base + S + W + 1) win_on = 1'b0;
         if (resp_valid === 1'b1) begin
            got = n;
            resp_ready = 1'b0;
         end else begin
            resp_ready = 1'($urandom % 2);
            @(posedge clk); #1;
            n++;
         end
      end
      win_on = 1'b0;
      resp_ready = 1'b0;
      chk("valid_cycle", got, exp_cyc, 0);
      chk("ro_en_mask", en_bad, 0, 0);
      chk("resp_err", resp_err, legal ? 0 : 1, 0);
      if (!legal) begin
         chk("err_count_a", count_a, 0, 0);
         chk("err_count_b", count_b, 0, 0);
         chk("err_bit", resp_bit, 0, 0);
         chk("err_tie", resp_tie, 0, 0);
         chk("err_sat", resp_sat, 0, 0);
      end else begin
         ra = ref_cnt[a];
         rb = ref_cnt[b];
         chk("count_a", count_a, ra, 1);
         chk("count_b", count_b, rb, 1);
         chk("resp_sat", resp_sat, 0, 0);
         if (same) begin
            chk("tie_flag", resp_tie, 1, 0);
            chk("tie_bit", resp_bit, 0, 0);
         end else if (ra > rb + 2 || rb > ra + 2) begin
            chk("resp_bit", resp_bit, (ra > rb) ? 1 : 0, 0);
            chk("resp_tie", resp_tie, 0, 0);
         end
      end

      snap = {resp_bit, resp_tie, resp_sat, resp_err, count_a, count_b};
      hold_bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if ({resp_bit, resp_tie, resp_sat, resp_err, count_a, count_b} !== snap ||
             resp_valid !== 1'b1) hold_bad++;
      end
      chk("hold_stable", hold_bad, 0, 0);
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("valid_drop", resp_valid, 0, 0);
      chk("ready_back", chal_ready, 1, 0);
   endtask

   initial begin
      int a, b, pa, pb, n, got, bad;
      rst_n = 1'b0;
      chal_valid = 1'b0; chal_a = '0; chal_b = '0; resp_ready = 1'b0;
      s_valid = 1'b0; s_a = '0; s_b = '0; s_rready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ro_en", ro_en, 0, 0);
      chk("rst_valid", resp_valid, 0, 0);
      chk("rst_flags", {resp_bit, resp_tie, resp_sat, resp_err}, 0, 0);
      chk("rst_counts", {count_a, count_b}, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", chal_ready, 1, 0);

      // 10-clk and 14-clk oscillators, both orders
      set_osc(3, 100, 0);
      set_osc(7, 140, 13);
      run_chal(3, 7, 1'b0);
      run_chal(7, 3, 1'b0);

      // identical period and phase
      set_osc(2, 120, 5);
      set_osc(9, 120, 5);
      run_chal(2, 9, 1'b1);

      // illegal challenges
      run_chal(5, 5, 1'b0);
      run_chal(16, 0, 1'b0);

      // random pairs with clearly separated periods
      repeat (3) begin
         a  = $urandom_range(0, NRO - 1);
         b  = (a + $urandom_range(1, NRO - 1)) % NRO;
         pa = $urandom_range(40, 150);
         pb = pa + $urandom_range(30, 120);
         if ($urandom % 2) begin
            set_osc(a, pa, $urandom_range(0, pa - 1));
            set_osc(b, pb, $urandom_range(0, pb - 1));
         end else begin
            set_osc(a, pb, $urandom_range(0, pb - 1));
            set_osc(b, pa, $urandom_range(0, pa - 1));
         end
         run_chal(a, b, 1'b0);
      end

      // reset in the middle of COUNT
      set_osc(1, 90, 3);
      set_osc(12, 130, 7);
      @(negedge clk);
      chal_a = 5'd1; chal_b = 5'd12; chal_valid = 1'b1;
      @(posedge clk); #1;
      chal_valid = 1'b0;
      repeat (S + 100) @(posedge clk);
      #1;
      chk("en_before_rst", ro_en, 16'h1002, 0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ro_en", ro_en, 0, 0);
      chk("rst_mid_valid", resp_valid, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_mid_ready", chal_ready, 1, 0);
      bad = 0;
      repeat (S + W + 10) begin
         @(posedge clk); #1;
         if (resp_valid !== 1'b0 || ro_en !== '0) bad++;
      end
      chk("rst_discard", bad, 0, 0);

      // 4-bit counters against a 4-clk oscillator: must stick at 15
      @(negedge clk);
      s_a = 5'd4; s_b = 5'd11; s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      n = 1; got = -1;
      while (got < 0 && n <= ROUNDS * (SS + SWIN + 1) + 50) begin
         if (s_rvalid === 1'b1) got = n;
         else begin
            @(posedge clk); #1;
            n++;
         end
      end
      chk("sat_valid_cycle", got, ROUNDS * (SS + SWIN + 1) + 1, 0);
      chk("sat_count_a", s_cnt_a, 15, 0);
      chk("sat_count_b", s_cnt_b, 15, 0);
      chk("sat_flag", s_sat, 1, 0);
      chk("sat_tie", s_tie, 1, 0);
      chk("sat_bit", s_bit, 0, 0);
      chk("sat_err", s_err, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
